// File: rtl/vend_controller.sv
// Vending machine sequencing controller: coin credit, slot selection with per-slot stock,
// and req/ack handshakes towards the dispenser and change-return actuators.
module vend_controller #(
    parameter int unsigned NUM_SLOTS  = 4,
    parameter int unsigned PRICE      = 3,
    parameter int unsigned CREDIT_W   = 4,
    parameter int unsigned MAX_CREDIT = 15,
    parameter int unsigned STOCK_W    = 4,
    parameter int unsigned INIT_STOCK = 3,
    parameter int unsigned SLOT_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           in,
    input  logic                 sel_valid,
    input  logic [SLOT_W-1:0]    sel_slot,
    input  logic                 cancel,
    output logic                 disp_req,
    output logic [SLOT_W-1:0]    disp_slot,
    input  logic                 disp_ack,
    output logic [1:0]           change,
    input  logic                 change_ack,
    output logic                 out,
    output logic                 coin_reject,
    output logic [CREDIT_W-1:0]  credit,
    output logic [NUM_SLOTS-1:0] sold_out,
    output logic                 busy
);

    typedef enum logic [1:0] {StIdle, StCredit, StDispense, StChange} state_e;

    localparam logic [CREDIT_W-1:0] PriceC = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W:0]   MaxC   = (CREDIT_W + 1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] One    = CREDIT_W'(1);
    localparam logic [CREDIT_W-1:0] Two    = CREDIT_W'(2);

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [STOCK_W-1:0]  stock_q [NUM_SLOTS];
    logic [STOCK_W-1:0]  stock_d [NUM_SLOTS];
    logic [SLOT_W-1:0]   disp_slot_q, disp_slot_d;
    logic [1:0]          change_q, change_d;
    logic                out_q, out_d;
    logic                reject_q, reject_d;

    logic [CREDIT_W-1:0] coin_val;
    logic [CREDIT_W:0]   coin_sum;
    logic [CREDIT_W-1:0] chg_val;
    logic [STOCK_W-1:0]  stock_sel;
    logic                slot_ok;
    logic                sel_ok;

    always_comb begin
        stock_sel = '0;
        slot_ok   = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (sel_slot == SLOT_W'(i)) begin
                stock_sel = stock_q[i];
                slot_ok   = 1'b1;
            end
        end
    end

    always_comb begin
        unique case (in)
            2'b01:   coin_val = One;
            2'b10:   coin_val = Two;
            default: coin_val = '0;
        endcase
        coin_sum = {1'b0, credit_q} + {1'b0, coin_val};
        chg_val  = (change_q == 2'b10) ? Two : One;
        sel_ok   = sel_valid && slot_ok && (credit_q >= PriceC) && (stock_sel != '0);
    end

    always_comb begin
        state_d     = state_q;
        credit_d    = credit_q;
        stock_d     = stock_q;
        disp_slot_d = disp_slot_q;
        change_d    = change_q;
        out_d       = 1'b0;
        reject_d    = 1'b0;

        unique case (state_q)
            StIdle, StCredit: begin
                if (cancel && credit_q != '0) begin
                    state_d  = StChange;
                    change_d = (credit_q >= Two) ? 2'b10 : 2'b01;
                    reject_d = (in != 2'b00);
                end else if (sel_ok) begin
                    credit_d    = credit_q - PriceC;
                    disp_slot_d = sel_slot;
                    state_d     = StDispense;
                    reject_d    = (in != 2'b00);
                end else if (in == 2'b11) begin
                    reject_d = 1'b1;
                end else if (in != 2'b00) begin
                    if (coin_sum <= MaxC) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                        state_d  = StCredit;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            StDispense: begin
                reject_d = (in != 2'b00);
                if (disp_ack) begin
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        if (disp_slot_q == SLOT_W'(i)) begin
                            stock_d[i] = stock_q[i] - STOCK_W'(1);
                        end
                    end
                    out_d = 1'b1;
                    if (credit_q != '0) begin
                        state_d  = StChange;
                        change_d = (credit_q >= Two) ? 2'b10 : 2'b01;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StChange: begin
                reject_d = (in != 2'b00);
                // change_q==0 is the one-cycle gap between returned coins
                if (change_q == 2'b00) begin
                    change_d = (credit_q >= Two) ? 2'b10 : 2'b01;
                end else if (change_ack) begin
                    credit_d = credit_q - chg_val;
                    change_d = 2'b00;
                    if (credit_d == '0) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            credit_q    <= '0;
            disp_slot_q <= '0;
            change_q    <= 2'b00;
            out_q       <= 1'b0;
            reject_q    <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                stock_q[i] <= STOCK_W'(INIT_STOCK);
            end
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            disp_slot_q <= disp_slot_d;
            change_q    <= change_d;
            out_q       <= out_d;
            reject_q    <= reject_d;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                stock_q[i] <= stock_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            sold_out[i] = (stock_q[i] == '0);
        end
    end

    assign disp_req    = (state_q == StDispense);
    assign busy        = (state_q == StDispense) || (state_q == StChange);
    assign disp_slot   = disp_slot_q;
    assign change      = change_q;
    assign out         = out_q;
    assign coin_reject = reject_q;
    assign credit      = credit_q;

endmodule
